mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_latency_counter.sv | 52 +++++
 rtl/mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder slice. It holds the bus word
// width, the latency counter width, the FSM state encodings, and a helper that
// flags addresses lying outside the implemented storage.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int WORD_SIZE = 16;
    // LATENCY is limited to 1..15, so four bits are enough.
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // True when any address bit at or above abits is set.
    function automatic logic addr_out_of_range(input logic [WORD_SIZE-1:0] addr,
                                               input int                   abits);
        return ((addr >> abits) != {WORD_SIZE{1'b0}});
    endfunction

endpackage

// File: rtl/mem_responder_latency_counter.sv
// -----------------------------------------------------------------------------
// latency_counter
// This is a loadable down-counter that spaces a captured request from its
// response. A load takes priority over a decrement. Decrements stop at zero.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset (count -> 0)
//   load_i      load load_val_i on the next edge
//   load_val_i  value to load
//   dec_i       decrement on the next edge (ignored at zero)
//   zero_o      count is currently zero
// -----------------------------------------------------------------------------
module latency_counter
    import mem_responder_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load, saturating decrement, or hold.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// This is a fixed-latency memory model that answers CPU read and write
// requests over a shared tri-state data bus.
// Optional feature: define RESP_ERR_EN to add err_o. err_o flags an
// out-of-range access in RESP, and a read+write collision on the capture edge.
// Ports:
//   clk         clock, rising edge
//   reset_n     asynchronous reset, ACTIVE-HIGH despite the name
//   readM       read request level
//   writeM      write request level (wins over readM)
//   address     word address
//   data        shared bus: CPU drives write data, responder drives read data
//   inputReady  one-cycle pulse, read data valid on data
//   ackOutput   one-cycle pulse, write committed (or dropped if out of range)
//   err_o       (RESP_ERR_EN only) one-cycle error pulse
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 8,
    parameter int LATENCY       = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 inputReady,
    output logic                 ackOutput
`ifdef RESP_ERR_EN
    ,
    output logic                 err_o
`endif
);

    state_t                   state_q, state_d;
    logic                     is_write_q, is_write_d;
    logic [WORD_SIZE-1:0]     addr_q, addr_d;
    logic [WORD_SIZE-1:0]     wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]     rdata_q, rdata_d;
    logic                     ready_q, ready_d;
    logic                     ack_q, ack_d;
`ifdef RESP_ERR_EN
    logic                     err_q, err_d;
`endif

    logic                     cnt_load_s;
    logic                     cnt_dec_s;
    logic                     cnt_zero_s;
    logic                     oor_s;
    logic                     mem_we_s;
    logic [MEM_ADDR_BITS-1:0] idx_s;

    // Storage is not reset, so its contents are unknown until they are written.
    logic [WORD_SIZE-1:0]     mem_q [2**MEM_ADDR_BITS];

    assign oor_s = addr_out_of_range(addr_q, MEM_ADDR_BITS);
    assign idx_s = addr_q[MEM_ADDR_BITS-1:0];
    // Commit on the RESP exit edge. Gate with reset so an asynchronous reset
    // cannot let a pending write reach storage.
    assign mem_we_s = (state_q == RESP) && is_write_q && !oor_s && !reset_n;

    latency_counter #(
        .W (CNT_W)
    ) u_latency_counter (
        .clk_i      (clk),
        .rst_i      (reset_n),
        .load_i     (cnt_load_s),
        .load_val_i (CNT_W'(LATENCY)),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s)
    );

    // Next-state, capture and registered-output logic.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        ack_d      = 1'b0;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
`ifdef RESP_ERR_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (writeM) begin
                    is_write_d = 1'b1;
                    addr_d     = address;
                    wdata_d    = data;
                    cnt_load_s = 1'b1;
                    state_d    = BUSY;
`ifdef RESP_ERR_EN
                    err_d      = readM;
`endif
                end else if (readM) begin
                    is_write_d = 1'b0;
                    addr_d     = address;
                    cnt_load_s = 1'b1;
                    state_d    = BUSY;
                end else begin
                    state_d    = IDLE;
                end
            end
            BUSY: begin
                // Abort if the request that started this access goes away.
                if (is_write_q ? !writeM : !readM) begin
                    state_d = IDLE;
                end else if (cnt_zero_s) begin
                    state_d = RESP;
                    ack_d   = is_write_q;
                    ready_d = !is_write_q;
                    rdata_d = oor_s ? {WORD_SIZE{1'b0}} : mem_q[idx_s];
`ifdef RESP_ERR_EN
                    err_d   = oor_s;
`endif
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            RESP: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                // Wait for the request to drop so that a held request is served once.
                if (!readM && !writeM) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, request capture and output registers.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            addr_q     <= {WORD_SIZE{1'b0}};
            wdata_q    <= {WORD_SIZE{1'b0}};
            rdata_q    <= {WORD_SIZE{1'b0}};
            ready_q    <= 1'b0;
            ack_q      <= 1'b0;
`ifdef RESP_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            ack_q      <= ack_d;
`ifdef RESP_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_s] <= wdata_q;
        end
    end

    assign data       = ready_q ? rdata_q : {WORD_SIZE{1'bz}};
    assign inputReady = ready_q;
    assign ackOutput  = ack_q;
`ifdef RESP_ERR_EN
    assign err_o      = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder with LATENCY=2 and MEM_ADDR_BITS=8.
// Expected responses are queued when a request is issued. They are popped when
// inputReady or ackOutput pulses.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        readM;
    logic        writeM;
    logic [15:0] address;
    logic [15:0] tb_dat;
    logic        tb_drv;
    wire  [15:0] data;
    logic        inputReady;
    logic        ackOutput;
`ifdef RESP_ERR_EN
    logic        err_o;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_read;
        logic [15:0] rdata;
        logic        oor_err;
        logic        cap_err;
    } exp_t;

    exp_t exp_q[$];

    assign data = tb_drv ? tb_dat : 16'hzzzz;

    always #5 clk = ~clk;

    mem_responder #(
        .MEM_ADDR_BITS (8),
        .LATENCY       (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .readM      (readM),
        .writeM     (writeM),
        .address    (address),
        .data       (data),
        .inputReady (inputReady),
        .ackOutput  (ackOutput)
`ifdef RESP_ERR_EN
        ,
        .err_o      (err_o)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A released bus reads as Z on 4-state simulators and as 0 on 2-state ones.
    task automatic chk_released(input string tag);
        checks++;
        assert ((data === 16'hzzzz) || (data === 16'h0000)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=released", tag, data);
        end
    endtask

    function automatic void expect_resp(input logic rd, input logic [15:0] rdata,
                                        input logic oor, input logic cap);
        exp_t e;
        e.is_read = rd;
        e.rdata   = rdata;
        e.oor_err = oor;
        e.cap_err = cap;
        exp_q.push_back(e);
    endfunction

    task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        readM   = rd;
        writeM  = wr;
        address = a;
        tb_dat  = d;
        tb_drv  = wr;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        readM  = 1'b0;
        writeM = 1'b0;
        tb_drv = 1'b0;
        @(negedge clk);
    endtask

    // Called right after req(). It waits for the response pulse and checks the
    // pulse against the front of the queue.
    task automatic wait_response(input string tag);
        int   n;
        bit   seen;
        logic cap;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        cap  = 1'b0;
        e    = exp_q.pop_front();
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
`ifdef RESP_ERR_EN
            if (n == 1) cap = err_o;
`endif
            if (inputReady === 1'b1 || ackOutput === 1'b1) begin
                seen = 1'b1;
            end else if (e.is_read) begin
                chk_released({tag, "_z_before"});
            end
        end
        chk({tag, "_seen"}, {15'd0, seen}, 16'd1);
        if (seen) begin
            chk({tag, "_latency"}, 16'(n), 16'd4);
            chk({tag, "_ready"}, {15'd0, inputReady}, {15'd0, e.is_read});
            chk({tag, "_ack"}, {15'd0, ackOutput}, {15'd0, !e.is_read});
            if (e.is_read) chk({tag, "_data"}, data, e.rdata);
`ifdef RESP_ERR_EN
            chk({tag, "_err_resp"}, {15'd0, err_o}, {15'd0, e.oor_err});
            chk({tag, "_err_cap"}, {15'd0, cap}, {15'd0, e.cap_err});
`endif
            @(negedge clk);
            chk({tag, "_ready_after"}, {15'd0, inputReady}, 16'd0);
            chk({tag, "_ack_after"}, {15'd0, ackOutput}, 16'd0);
            if (e.is_read) chk_released({tag, "_z_after"});
        end
    endtask

    initial begin
        int acks;
        reset_n = 1'b1;
        readM   = 1'b0;
        writeM  = 1'b0;
        address = 16'h0000;
        tb_dat  = 16'h0000;
        tb_drv  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {15'd0, inputReady}, 16'd0);
        chk("rst_ack", {15'd0, ackOutput}, 16'd0);
        chk_released("rst_data");
        reset_n = 1'b0;

        // Write BEEF to 0x0010, then hold writeM to confirm it does not retrigger.
        expect_resp(1'b0, 16'h0000, 1'b0, 1'b0);
        req(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        wait_response("wr_beef");
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            acks += int'(ackOutput);
        end
        chk("no_retrigger", 16'(acks), 16'd0);
        idle_bus();

        // Read back 0x0010.
        expect_resp(1'b1, 16'hBEEF, 1'b0, 1'b0);
        req(1'b1, 1'b0, 16'h0010, 16'h0000);
        wait_response("rd_beef");
        idle_bus();

        // Out-of-range read returns zero.
        expect_resp(1'b1, 16'h0000, 1'b1, 1'b0);
        req(1'b1, 1'b0, 16'h0100, 16'h0000);
        wait_response("rd_oor");
        idle_bus();

        // Out-of-range write is acked but must not alias onto index 0x10.
        expect_resp(1'b0, 16'h0000, 1'b1, 1'b0);
        req(1'b0, 1'b1, 16'h0110, 16'h7777);
        wait_response("wr_oor");
        idle_bus();
        expect_resp(1'b1, 16'hBEEF, 1'b0, 1'b0);
        req(1'b1, 1'b0, 16'h0010, 16'h0000);
        wait_response("rd_alias");
        idle_bus();

        // readM and writeM together: the write wins.
        expect_resp(1'b0, 16'h0000, 1'b0, 1'b1);
        req(1'b1, 1'b1, 16'h0005, 16'h1234);
        wait_response("wr_both");
        idle_bus();
        expect_resp(1'b1, 16'h1234, 1'b0, 1'b0);
        req(1'b1, 1'b0, 16'h0005, 16'h0000);
        wait_response("rd_both");
        idle_bus();

        // writeM dropped one cycle into BUSY aborts the write.
        req(1'b0, 1'b1, 16'h0005, 16'hAAAA);
        @(negedge clk);
        writeM = 1'b0;
        tb_drv = 1'b0;
        acks   = 0;
        repeat (8) begin
            @(negedge clk);
            acks += int'(ackOutput);
        end
        chk("abort_no_ack", 16'(acks), 16'd0);
        expect_resp(1'b1, 16'h1234, 1'b0, 1'b0);
        req(1'b1, 1'b0, 16'h0005, 16'h0000);
        wait_response("rd_abort");
        idle_bus();

        // Reset during BUSY of a write discards the write.
        req(1'b0, 1'b1, 16'h0005, 16'h5555);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_busy_ready", {15'd0, inputReady}, 16'd0);
        chk("rst_busy_ack", {15'd0, ackOutput}, 16'd0);
        @(negedge clk);
        writeM  = 1'b0;
        tb_drv  = 1'b0;
        reset_n = 1'b0;
        expect_resp(1'b1, 16'h1234, 1'b0, 1'b0);
        req(1'b1, 1'b0, 16'h0005, 16'h0000);
        wait_response("rd_after_rst");
        idle_bus();

        // Reset in the RESP cycle of a read releases the bus at once.
        req(1'b1, 1'b0, 16'h0010, 16'h0000);
        repeat (4) @(negedge clk);
        chk("resp_ready_pre", {15'd0, inputReady}, 16'd1);
        chk("resp_data_pre", data, 16'hBEEF);
        reset_n = 1'b1;
        #1;
        chk("rst_resp_ready", {15'd0, inputReady}, 16'd0);
        chk_released("rst_resp_data");
        @(negedge clk);
        readM   = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
